// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Arbitrates two cores' instruction and data request ports
//                onto one shared RAM port. Data requests win over
//                instruction requests. A round-robin pointer, shared by
//                both classes, chooses between the two cores within a
//                class. Each transaction runs IDLE -> ACCESS -> RESP. In
//                RESP the winner's wait line is released for one cycle.
//
//  Ports
//    CLK, nRST          clock (rising edge), asynchronous active-low reset
//    iREN  / iaddr      per-core instruction read request and address
//    dREN  / dWEN       per-core data read / write request
//    daddr / dstore     per-core data address and write data
//    iwait / dwait      per-core stall lines
//    iload / dload      per-core captured read data
//    ram_ren / ram_wen  RAM strobes, active only in ACCESS
//    ram_addr/ram_store latched address and write data
//    ram_load/ram_ready RAM read data and one-cycle completion pulse
//
//  Revision    : 1.0  initial release
// ============================================================================
module memory_arbiter #(
    parameter int NUM_BITS = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [1:0]               iREN,
    input  logic [1:0][NUM_BITS-1:0] iaddr,
    input  logic [1:0]               dREN,
    input  logic [1:0]               dWEN,
    input  logic [1:0][NUM_BITS-1:0] daddr,
    input  logic [1:0][NUM_BITS-1:0] dstore,
    output logic [1:0]               iwait,
    output logic [1:0]               dwait,
    output logic [1:0][NUM_BITS-1:0] iload,
    output logic [1:0][NUM_BITS-1:0] dload,
    output logic                     ram_ren,
    output logic                     ram_wen,
    output logic [NUM_BITS-1:0]      ram_addr,
    output logic [NUM_BITS-1:0]      ram_store,
    input  logic [NUM_BITS-1:0]      ram_load,
    input  logic                     ram_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched transaction: source class/core, address, store data, direction
    logic                     r_rr;
    logic                     r_is_data;
    logic                     r_core;
    logic                     r_write;
    logic [NUM_BITS-1:0]      r_addr;
    logic [NUM_BITS-1:0]      r_store;
    logic [1:0][NUM_BITS-1:0] r_iload;
    logic [1:0][NUM_BITS-1:0] r_dload;

    // Arbitration of the currently pending sources
    logic [1:0]          w_dpend;
    logic [1:0]          w_cls;
    logic                w_any;
    logic                w_sel_data;
    logic                w_sel_core;
    logic                w_sel_write;
    logic [NUM_BITS-1:0] w_sel_addr;
    logic [NUM_BITS-1:0] w_sel_store;

    always_comb begin
        w_dpend     = dREN | dWEN;
        w_any       = (|w_dpend) | (|iREN);
        w_sel_data  = |w_dpend;
        w_cls       = w_sel_data ? w_dpend : iREN;
        // Both cores pending in the winning class: the pointer decides.
        // Otherwise bit 1 alone identifies the single pending core.
        w_sel_core  = (w_cls == 2'b11) ? r_rr : w_cls[1];
        // A write takes priority over a read from the same core
        w_sel_write = w_sel_data & dWEN[w_sel_core];
        w_sel_addr  = w_sel_data ? daddr[w_sel_core] : iaddr[w_sel_core];
        w_sel_store = w_sel_data ? dstore[w_sel_core] : '0;
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and RAM strobes
    always_comb begin
        w_next  = r_state;
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                ram_ren = ~r_write;
                ram_wen = r_write;
                if (ram_ready) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Wait lines follow the requests, except the winner is released in RESP
    always_comb begin
        iwait = iREN;
        dwait = w_dpend;
        if (r_state == RESP) begin
            if (r_is_data) begin
                dwait[r_core] = 1'b0;
            end else begin
                iwait[r_core] = 1'b0;
            end
        end
    end

    // Transaction latch, load capture and round-robin pointer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr      <= 1'b0;
            r_is_data <= 1'b0;
            r_core    <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_store   <= '0;
            r_iload   <= '0;
            r_dload   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_is_data <= w_sel_data;
                        r_core    <= w_sel_core;
                        r_write   <= w_sel_write;
                        r_addr    <= w_sel_addr;
                        r_store   <= w_sel_store;
                    end
                end
                ACCESS: begin
                    // The load register is updated even if the requester
                    // has since withdrawn its request.
                    if (ram_ready && !r_write) begin
                        if (r_is_data) begin
                            r_dload[r_core] <= ram_load;
                        end else begin
                            r_iload[r_core] <= ram_load;
                        end
                    end
                end
                RESP: begin
                    r_rr <= ~r_core;
                end
                default: begin
                end
            endcase
        end
    end

    assign iload     = r_iload;
    assign dload     = r_dload;
    assign ram_addr  = r_addr;
    assign ram_store = r_store;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Directed self-checking bench for memory_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int NUM_BITS = 32;

    logic                     CLK;
    logic                     nRST;
    logic [1:0]               iREN;
    logic [1:0][NUM_BITS-1:0] iaddr;
    logic [1:0]               dREN;
    logic [1:0]               dWEN;
    logic [1:0][NUM_BITS-1:0] daddr;
    logic [1:0][NUM_BITS-1:0] dstore;
    logic [1:0]               iwait;
    logic [1:0]               dwait;
    logic [1:0][NUM_BITS-1:0] iload;
    logic [1:0][NUM_BITS-1:0] dload;
    logic                     ram_ren;
    logic                     ram_wen;
    logic [NUM_BITS-1:0]      ram_addr;
    logic [NUM_BITS-1:0]      ram_store;
    logic [NUM_BITS-1:0]      ram_load;
    logic                     ram_ready;

    int n_checks = 0;
    int n_fail   = 0;

    memory_arbiter #(.NUM_BITS(NUM_BITS)) u_dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .iwait     (iwait),
        .dwait     (dwait),
        .iload     (iload),
        .dload     (dload),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST      = 1'b0;
        iREN      = '0;
        iaddr     = '0;
        dREN      = '0;
        dWEN      = '0;
        daddr     = '0;
        dstore    = '0;
        ram_load  = '0;
        ram_ready = 1'b0;
        #3;
        check_eq("rst_ren",   ram_ren,  1'b0);
        check_eq("rst_wen",   ram_wen,  1'b0);
        check_eq("rst_addr",  ram_addr, 32'h0);
        check_eq("rst_iload", iload,    64'h0);
        check_eq("rst_dload", dload,    64'h0);
        check_eq("rst_waits", {iwait, dwait}, 4'b0000);
        cyc();
        nRST = 1'b1;

        // ---------------- single instruction read ----------------
        iREN = 2'b01; iaddr[0] = 32'h100;
        #1;
        check_eq("rd_idle_ren", ram_ren, 1'b0);
        check_eq("rd_idle_iwait", iwait, 2'b01);
        cyc();                                   // ACCESS cycle 1
        check_eq("rd_acc1_ren", ram_ren, 1'b1);
        check_eq("rd_acc1_addr", ram_addr, 32'h100);
        check_eq("rd_acc1_iwait", iwait, 2'b01);
        cyc();                                   // ACCESS cycle 2
        ram_ready = 1'b1; ram_load = 32'hDEADBEEF;
        #1;
        check_eq("rd_acc2_ren", ram_ren, 1'b1);
        cyc();                                   // RESP
        ram_ready = 1'b0;
        #1;
        check_eq("rd_resp_ren", ram_ren, 1'b0);
        check_eq("rd_resp_iwait", iwait, 2'b00);
        check_eq("rd_resp_iload0", iload[0], 32'hDEADBEEF);
        iREN = 2'b00;
        cyc();                                   // IDLE
        check_eq("rd_idle2_ren", ram_ren, 1'b0);
        // ram_ready while idle must be ignored
        ram_ready = 1'b1; ram_load = 32'h55555555;
        cyc();
        ram_ready = 1'b0;
        #1;
        check_eq("idle_ready_ren", ram_ren, 1'b0);
        check_eq("idle_ready_iload", iload, {32'h0, 32'hDEADBEEF});

        // ---------------- data over instruction ----------------
        iREN = 2'b01; iaddr[0] = 32'h200;
        dREN = 2'b01; daddr[0] = 32'h300;
        cyc();                                   // ACCESS for d0
        check_eq("dvi_d_addr", ram_addr, 32'h300);
        check_eq("dvi_d_ren", {ram_ren, ram_wen}, 2'b10);
        ram_ready = 1'b1; ram_load = 32'h11111111;
        cyc();                                   // RESP d0
        ram_ready = 1'b0;
        #1;
        check_eq("dvi_d_dwait", dwait, 2'b00);
        check_eq("dvi_d_iwait", iwait, 2'b01);
        check_eq("dvi_d_dload0", dload[0], 32'h11111111);
        dREN = 2'b00;
        cyc();                                   // IDLE
        check_eq("dvi_idle_ren", ram_ren, 1'b0);
        check_eq("dvi_idle_iwait", iwait, 2'b01);
        cyc();                                   // ACCESS for i0
        check_eq("dvi_i_addr", ram_addr, 32'h200);
        check_eq("dvi_i_ren", ram_ren, 1'b1);
        ram_ready = 1'b1; ram_load = 32'h22222222;
        cyc();                                   // RESP i0
        ram_ready = 1'b0;
        #1;
        check_eq("dvi_i_iwait", iwait, 2'b00);
        check_eq("dvi_i_iload0", iload[0], 32'h22222222);
        check_eq("dvi_i_dload0", dload[0], 32'h11111111);
        iREN = 2'b00;
        cyc();                                   // IDLE

        // ---------------- round-robin writes (rr reset to 0) ----------------
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        dWEN = 2'b11;
        daddr[0] = 32'h10; daddr[1] = 32'h20;
        dstore[0] = 32'hA; dstore[1] = 32'hB;
        cyc();                                   // ACCESS core 0
        check_eq("rr1_addr", ram_addr, 32'h10);
        check_eq("rr1_store", ram_store, 32'hA);
        check_eq("rr1_strobes", {ram_ren, ram_wen}, 2'b01);
        check_eq("rr1_dwait", dwait, 2'b11);
        ram_ready = 1'b1; ram_load = 32'hFFFFFFFF;
        cyc();                                   // RESP core 0
        ram_ready = 1'b0;
        #1;
        check_eq("rr1_resp_dwait", dwait, 2'b10);
        check_eq("rr1_dload", dload, 64'h0);
        cyc();                                   // IDLE
        check_eq("rr_idle_strobes", {ram_ren, ram_wen}, 2'b00);
        check_eq("rr_idle_dwait", dwait, 2'b11);
        cyc();                                   // ACCESS core 1
        check_eq("rr2_addr", ram_addr, 32'h20);
        check_eq("rr2_store", ram_store, 32'hB);
        check_eq("rr2_wen", ram_wen, 1'b1);
        ram_ready = 1'b1;
        cyc();                                   // RESP core 1
        ram_ready = 1'b0;
        #1;
        check_eq("rr2_resp_dwait", dwait, 2'b01);
        check_eq("rr2_dload", dload, 64'h0);
        cyc();                                   // IDLE
        cyc();                                   // ACCESS: core 0 again
        check_eq("rr3_addr", ram_addr, 32'h10);
        ram_ready = 1'b1;
        cyc();                                   // RESP
        ram_ready = 1'b0;
        dWEN = 2'b00;
        cyc();                                   // IDLE, rr now 1

        // ---------------- write priority over read ----------------
        dREN = 2'b10; dWEN = 2'b10;
        daddr[1] = 32'h40; dstore[1] = 32'hC;
        cyc();                                   // ACCESS
        check_eq("wp_strobes", {ram_ren, ram_wen}, 2'b01);
        check_eq("wp_addr", ram_addr, 32'h40);
        check_eq("wp_store", ram_store, 32'hC);
        ram_ready = 1'b1; ram_load = 32'h33333333;
        cyc();                                   // RESP
        ram_ready = 1'b0;
        #1;
        check_eq("wp_dwait", dwait, 2'b00);
        check_eq("wp_dload1", dload[1], 32'h0);
        dREN = 2'b00; dWEN = 2'b00;
        cyc();                                   // IDLE

        // ---------------- request dropped mid-ACCESS ----------------
        dREN = 2'b01; daddr[0] = 32'h50;
        cyc();                                   // ACCESS
        dREN = 2'b00;
        #1;
        check_eq("ab_ren", ram_ren, 1'b1);
        check_eq("ab_dwait", dwait, 2'b00);
        cyc();
        check_eq("ab_ren2", ram_ren, 1'b1);
        ram_ready = 1'b1; ram_load = 32'h44444444;
        cyc();                                   // RESP
        ram_ready = 1'b0;
        #1;
        check_eq("ab_dload0", dload[0], 32'h44444444);
        check_eq("ab_ren_resp", ram_ren, 1'b0);
        cyc();                                   // IDLE

        // ---------------- reset mid-ACCESS ----------------
        iREN = 2'b10; iaddr[1] = 32'h60;
        cyc();                                   // ACCESS
        check_eq("rs_ren_before", ram_ren, 1'b1);
        check_eq("rs_addr", ram_addr, 32'h60);
        #1;
        nRST = 1'b0;
        #1;
        check_eq("rs_ren_async", ram_ren, 1'b0);
        check_eq("rs_iload", iload, 64'h0);
        check_eq("rs_dload", dload, 64'h0);
        check_eq("rs_iwait", iwait, 2'b10);
        iREN = 2'b00;
        cyc();
        nRST = 1'b1;
        #1;
        check_eq("rs_idle_ren", ram_ren, 1'b0);
        cyc();
        check_eq("rs_idle_ren2", {ram_ren, ram_wen}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Two-core memory arbiter sitting between both cores' instruction/data request ports and the single shared RAM port. It picks one pending request and issues it to RAM. When RAM completes, it routes the result back to exactly one requester, releasing that requester's wait line for one cycle. Arbitration: data before instruction; round-robin between cores within the same class.

## Interface
- NUM_BITS, 32, address/data width
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active low
- iREN  in  2  instruction read request, bit k = core k
- iaddr  in  2×NUM_BITS  instruction address per core (packed [1:0][NUM_BITS-1:0])
- dREN  in  2  data read request per core
- dWEN  in  2  data write request per core
- daddr  in  2×NUM_BITS  data address per core
- dstore  in  2×NUM_BITS  write data per core
- iwait  out  2  instruction stall per core
- dwait  out  2  data stall per core
- iload  out  2×NUM_BITS  instruction read data per core
- dload  out  2×NUM_BITS  data read data per core
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  NUM_BITS  RAM address
- ram_store  out  NUM_BITS  RAM write data
- ram_load  in  NUM_BITS  RAM read data, valid while ram_ready high
- ram_ready  in  1  RAM completion, one-cycle pulse

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset: IDLE, rr=0, latched src/addr/store/rw=0, all iload/dload=0.
- IDLE: the four sources are d0, d1, i0, i1. A data source is pending if dREN|dWEN is high; an instruction source is pending if iREN is high.
  - Any pending data source beats any instruction source.
  - Within a class, core rr wins when both cores are pending; otherwise the single pending core wins.
  - Latch winner id, address, store data and rw. A data source with dWEN=1 is a write; dWEN has priority over dREN from the same core. Instruction sources are always reads.
  - Go to ACCESS. With no pending source, stay in IDLE.
- ACCESS: ram_ren/ram_wen/ram_addr/ram_store are driven from the latched registers only.
  - Stay in ACCESS until ram_ready=1.
  - On ram_ready=1 with a read, capture ram_load into the winner's iload/dload register. Go to RESP.
- RESP: the winner's wait is low for this cycle. Set rr to ~winner core. Go to IDLE.
- Outside RESP and in IDLE/ACCESS:
  - iwait[k] = iREN[k]
  - dwait[k] = dREN[k]|dWEN[k]
  - Non-winners keep wait high through RESP.
- iload/dload hold their last captured value until overwritten. Writes leave dload unchanged.
- RAM strobes are 0 in IDLE and RESP. ram_addr/ram_store show latched values in all states.

## Timing
- Request seen in IDLE in cycle 0. ACCESS runs from cycle 1. If ram_ready arrives in cycle n≥1, the winner's wait is low and load is valid in cycle n+1 (RESP). IDLE follows in cycle n+2.
- Minimum 3 cycles per transaction. No back-to-back RAM strobes: at least 2 strobe-free cycles between transactions.
- Requester drops its request during ACCESS: the transaction still completes at RAM (no torn writes). The load register is still updated. No other output effect.
- ram_ready high in IDLE or RESP is ignored.
- Requester still asserting the same request after its RESP cycle is treated as a new transaction, re-arbitrated in the following IDLE.
- nRST low at any time, including mid-ACCESS: state returns to IDLE and strobes go to 0 asynchronously. Waits then follow the IDLE equations.
- Round-robin pointer is shared across classes. It updates only in RESP.

## Test plan
- Single read: iREN=01, iaddr[0]=0x100, RAM returns 0xDEADBEEF with ram_ready 2 cycles into ACCESS -> ram_ren high for exactly those cycles, ram_addr=0x100; iwait[0] low for one cycle with iload[0]=0xDEADBEEF; then IDLE.
- Data-over-instruction: iREN=01, dREN=01 together -> d0 served first, i0 next; iwait[0] stays high through d0's RESP.
- Round-robin: dWEN=11, daddr[0]=0x10/daddr[1]=0x20, dstore=0xA/0xB, rr=0 after reset -> writes issued as (0x10,0xA) then (0x20,0xB); dload unchanged; next contended pair starts with core 0 again.
- Write priority: dREN[1]=dWEN[1]=1 -> ram_wen=1, ram_ren=0, dload[1] unchanged.
- Abort/reset: drop dREN[0] mid-ACCESS -> RAM access still completes, dload[0] captured. Second run with nRST pulsed mid-ACCESS -> ram_ren falls in the same cycle, FSM in IDLE, all loads 0.
